// File: rtl/my_gates_bist.sv
// Built-in self-test for the seven-output gate bank: sweeps all eight {in1,in2,sel}
// vectors, compares each response with a golden model and reports the outcome.
`timescale 1ns/1ps

module my_gates_bist #(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             drv_in1,
    output logic             drv_in2,
    output logic             drv_sel,
    input  logic             obs_not,
    input  logic             obs_and,
    input  logic             obs_or,
    input  logic             obs_xor,
    input  logic             obs_mux,
    input  logic             obs_dmux1,
    input  logic             obs_dmux2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic [6:0]       fail_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state, state_next;
    logic [2:0]       idx, idx_next;
    logic [3:0]       settle_cnt, settle_next;
    logic [ERR_W-1:0] err_next;
    logic [2:0]       fvec_next;
    logic [6:0]       fmask_next;

    logic [6:0] golden;
    logic [6:0] observed;
    logic [6:0] mismatch;

    // The stimulus is the vector index itself, so it only moves when idx is re-registered.
    assign drv_in1 = idx[2];
    assign drv_in2 = idx[1];
    assign drv_sel = idx[0];

    always_comb begin
        golden = {~drv_in1,
                  drv_in1 & drv_in2,
                  drv_in1 | drv_in2,
                  drv_in1 ^ drv_in2,
                  drv_sel ? drv_in2 : drv_in1,
                  drv_sel ? 1'b0 : drv_in1,
                  drv_sel ? drv_in1 : 1'b0};
    end

    assign observed = {obs_not, obs_and, obs_or, obs_xor, obs_mux, obs_dmux1, obs_dmux2};
    assign mismatch = golden ^ observed;

    always_comb begin
        // NOTE: every next-value gets its default first, so no branch can infer a latch.
        state_next  = state;
        idx_next    = idx;
        settle_next = settle_cnt;
        err_next    = err_count;
        fvec_next   = fail_vec;
        fmask_next  = fail_mask;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = APPLY;
                    idx_next    = 3'd0;
                    settle_next = SETTLE_L;
                    err_next    = '0;
                    fvec_next   = 3'd0;
                    fmask_next  = 7'd0;
                end
            end
            APPLY: begin
                settle_next = settle_cnt - 4'd1;
                if (settle_cnt <= 4'd1) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (|mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_next = err_count + ERR_W'(1);
                    end
                    // A saturating counter never returns to zero, so zero marks "no failure yet".
                    if (err_count == '0) begin
                        fvec_next  = idx;
                        fmask_next = mismatch;
                    end
                end
                if (idx == 3'd7) begin
                    state_next = DONE;
                end else begin
                    idx_next    = idx + 3'd1;
                    settle_next = SETTLE_L;
                    state_next  = APPLY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state registers use non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            err_count  <= '0;
            fail_vec   <= 3'd0;
            fail_mask  <= 7'd0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            settle_cnt <= settle_next;
            err_count  <= err_next;
            fail_vec   <= fvec_next;
            fail_mask  <= fmask_next;
        end
    end

    assign busy = (state == APPLY) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

endmodule
